// File: rtl/logic_op_sequencer_if.sv
// -----------------------------------------------------------------------------
// logic_op_sequencer_if
//
// Purpose
//   Bundles the three signal groups of the logic-op sequencer into one
//   interface: the command stream in, the operand/select drive to the
//   registered logic unit and its result back, and the result stream out,
//   plus the status outputs (busy, fifo_count).
//
// Modports
//   slave  : the sequencer itself (accepts commands, drives the logic unit,
//            presents results and status).
//   master : the environment around it (command producer, logic unit,
//            result consumer).
//
// Parameters must match those of the attached logic_op_sequencer instance.
// -----------------------------------------------------------------------------
interface logic_op_sequencer_if #(
    parameter int SEL_LENGTH  = 2,
    parameter int DATA_LENGTH = 8,
    parameter int FIFO_DEPTH  = 4
);
    localparam int COUNT_LENGTH = $clog2(FIFO_DEPTH) + 1;

    // Command stream
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [DATA_LENGTH-1:0]  cmd_a;
    logic [DATA_LENGTH-1:0]  cmd_b;
    logic [SEL_LENGTH-1:0]   cmd_sel;

    // Logic unit drive and registered result
    logic [DATA_LENGTH-1:0]  lu_a;
    logic [DATA_LENGTH-1:0]  lu_b;
    logic [SEL_LENGTH-1:0]   lu_sel;
    logic [DATA_LENGTH-1:0]  lu_result;

    // Result stream
    logic                    res_valid;
    logic                    res_ready;
    logic [DATA_LENGTH-1:0]  res_data;

    // Status
    logic                    busy;
    logic [COUNT_LENGTH-1:0] fifo_count;

    modport slave (
        input  cmd_valid,
        input  cmd_a,
        input  cmd_b,
        input  cmd_sel,
        input  lu_result,
        input  res_ready,
        output cmd_ready,
        output lu_a,
        output lu_b,
        output lu_sel,
        output res_valid,
        output res_data,
        output busy,
        output fifo_count
    );

    modport master (
        output cmd_valid,
        output cmd_a,
        output cmd_b,
        output cmd_sel,
        output lu_result,
        output res_ready,
        input  cmd_ready,
        input  lu_a,
        input  lu_b,
        input  lu_sel,
        input  res_valid,
        input  res_data,
        input  busy,
        input  fifo_count
    );
endinterface

// File: rtl/logic_op_sequencer.sv
// -----------------------------------------------------------------------------
// logic_op_sequencer
//
// Purpose
//   Command-side initiator for a registered logic unit (AND/OR/XOR/NOT A on a
//   2-bit select, result registered on the clock edge). Commands are queued in
//   a small FIFO, issued one at a time to the unit, and the unit's result is
//   captured and returned on a valid/ready result stream in command order.
//
// Ports
//   clk    : single clock, rising edge.
//   rst_n  : asynchronous active-low reset.
//   bus    : logic_op_sequencer_if.slave
//              cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_sel  command stream in
//              lu_a/lu_b/lu_sel -> unit, lu_result <- unit
//              res_valid/res_ready/res_data             result stream out
//              busy, fifo_count                         status
//
// Timing
//   push edge -> (next edge) pop into ISSUE -> WAIT -> capture into HOLD.
//   res_valid rises two edges after the pop edge; with res_ready held high a
//   new command is issued every third cycle.
// -----------------------------------------------------------------------------
module logic_op_sequencer #(
    parameter int SEL_LENGTH  = 2,
    parameter int DATA_LENGTH = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    logic_op_sequencer_if.slave  bus
);
    localparam int PTR_LENGTH   = $clog2(FIFO_DEPTH);
    localparam int COUNT_LENGTH = PTR_LENGTH + 1;
    localparam int ENTRY_LENGTH = SEL_LENGTH + 2 * DATA_LENGTH;
    localparam logic [COUNT_LENGTH-1:0] COUNT_FULL = COUNT_LENGTH'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                  state_reg;
    logic [PTR_LENGTH-1:0]   wr_ptr_reg;
    logic [PTR_LENGTH-1:0]   rd_ptr_reg;
    logic [COUNT_LENGTH-1:0] count_reg;
    logic [COUNT_LENGTH-1:0] count_next;

    logic [DATA_LENGTH-1:0]  lu_a_reg;
    logic [DATA_LENGTH-1:0]  lu_b_reg;
    logic [SEL_LENGTH-1:0]   lu_sel_reg;
    logic [DATA_LENGTH-1:0]  res_data_reg;
    logic                    res_valid_reg;

    // FIFO storage, one packed entry {sel, b, a} per slot
    logic [ENTRY_LENGTH-1:0] entries [FIFO_DEPTH];
    logic [ENTRY_LENGTH-1:0] head_entry;
    logic [DATA_LENGTH-1:0]  head_a;
    logic [DATA_LENGTH-1:0]  head_b;
    logic [SEL_LENGTH-1:0]   head_sel;

    logic                    fifo_nonempty;
    logic                    cmd_ready_int;
    logic                    push;
    logic                    pop;
    logic                    res_accept;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    // cmd_ready depends on the registered count only, so a pop never opens a
    // slot for a push on the same edge; the freed slot is offered next cycle.
    assign fifo_nonempty = (count_reg != '0);
    assign cmd_ready_int = (count_reg != COUNT_FULL);
    assign push          = bus.cmd_valid && cmd_ready_int;
    assign res_accept    = res_valid_reg && bus.res_ready;

    // Pop decisions use the registered count: a command pushed this cycle into
    // an empty FIFO is not visible to the FSM until the following cycle.
    always_comb begin
        pop = 1'b0;
        case (state_reg)
            IDLE:    pop = fifo_nonempty;
            HOLD:    pop = res_accept && fifo_nonempty;
            default: pop = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // FIFO storage: one register per slot, written when the write pointer
    // selects it. Contents need no reset; a slot is only read once written.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [ENTRY_LENGTH-1:0] entry_reg;

            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PTR_LENGTH'(gi))) begin
                    entry_reg <= {bus.cmd_sel, bus.cmd_b, bus.cmd_a};
                end
            end

            assign entries[gi] = entry_reg;
        end
    endgenerate

    assign head_entry = entries[rd_ptr_reg];
    assign head_a     = head_entry[DATA_LENGTH-1:0];
    assign head_b     = head_entry[2*DATA_LENGTH-1:DATA_LENGTH];
    assign head_sel   = head_entry[ENTRY_LENGTH-1:2*DATA_LENGTH];

    // -------------------------------------------------------------------------
    // FIFO pointers and occupancy
    // -------------------------------------------------------------------------
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + COUNT_LENGTH'(1);
            2'b01:   count_next = count_reg - COUNT_LENGTH'(1);
            default: count_next = count_reg;   // idle, or push and pop cancel
        endcase
    end

    // Pointers are exactly log2(depth) bits wide, so wrap is natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_LENGTH'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_LENGTH'(1);
            end
            count_reg <= count_next;
        end
    end

    // -------------------------------------------------------------------------
    // Sequencing FSM with registered outputs
    //   IDLE  : wait for a queued command; pop loads the unit's operands.
    //   ISSUE : operands held at the unit for one full cycle; the unit
    //           registers its result on the closing edge.
    //   WAIT  : lu_result now reflects the issued command; capture it.
    //   HOLD  : result offered until accepted; on acceptance, chain straight
    //           into the next command if one is queued.
    // lu_* only change on a pop and otherwise keep the last issued values.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            lu_a_reg      <= '0;
            lu_b_reg      <= '0;
            lu_sel_reg    <= '0;
            res_data_reg  <= '0;
            res_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        lu_a_reg   <= head_a;
                        lu_b_reg   <= head_b;
                        lu_sel_reg <= head_sel;
                        state_reg  <= ISSUE;
                    end
                end

                ISSUE: begin
                    state_reg <= WAIT;
                end

                WAIT: begin
                    res_data_reg  <= bus.lu_result;
                    res_valid_reg <= 1'b1;
                    state_reg     <= HOLD;
                end

                HOLD: begin
                    if (res_accept) begin
                        res_valid_reg <= 1'b0;
                        if (pop) begin
                            lu_a_reg   <= head_a;
                            lu_b_reg   <= head_b;
                            lu_sel_reg <= head_sel;
                            state_reg  <= ISSUE;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.cmd_ready  = cmd_ready_int;
    assign bus.lu_a       = lu_a_reg;
    assign bus.lu_b       = lu_b_reg;
    assign bus.lu_sel     = lu_sel_reg;
    assign bus.res_valid  = res_valid_reg;
    assign bus.res_data   = res_data_reg;
    assign bus.busy       = (state_reg != IDLE) || fifo_nonempty;
    assign bus.fifo_count = count_reg;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_logic_op_sequencer
//
// Directed bench for logic_op_sequencer. A behavioural registered logic unit
// is attached to the lu_* signals. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_logic_op_sequencer;
    localparam int SEL_LENGTH  = 2;
    localparam int DATA_LENGTH = 8;
    localparam int FIFO_DEPTH  = 4;

    logic clk = 1'b0;
    logic rst_n;

    int check_count = 0;
    int pass_count  = 0;

    logic_op_sequencer_if #(
        .SEL_LENGTH (SEL_LENGTH),
        .DATA_LENGTH(DATA_LENGTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) bus ();

    logic_op_sequencer #(
        .SEL_LENGTH (SEL_LENGTH),
        .DATA_LENGTH(DATA_LENGTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Registered logic unit: 00 AND, 01 OR, 10 XOR, 11 NOT A
    always @(posedge clk) begin
        case (bus.lu_sel)
            2'b00:   bus.lu_result <= bus.lu_a & bus.lu_b;
            2'b01:   bus.lu_result <= bus.lu_a | bus.lu_b;
            2'b10:   bus.lu_result <= bus.lu_a ^ bus.lu_b;
            default: bus.lu_result <= ~bus.lu_a;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_sel   = s;
    endtask

    // Back-to-back op results for A=F0, B=3C
    logic [7:0] exp_ops [4] = '{8'h30, 8'hFC, 8'hCC, 8'h0F};

    // Full-FIFO command table and hand-computed results
    logic [7:0] fa   [6] = '{8'h01, 8'h0F, 8'hAA, 8'h55, 8'hC3, 8'h81};
    logic [7:0] fb   [6] = '{8'h02, 8'hF0, 8'h0F, 8'h00, 8'h3C, 8'h18};
    logic [1:0] fs   [6] = '{2'b01, 2'b10, 2'b00, 2'b11, 2'b01, 2'b10};
    logic [7:0] fexp [6] = '{8'h03, 8'hFF, 8'h0A, 8'hAA, 8'hFF, 8'h99};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int max_count;
        int idx;
        int accepted;
        logic rdy;

        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_sel   = '0;
        bus.res_ready = 1'b0;

        // ---------------- Reset state ----------------
        tick();
        tick();
        check("rst_res_valid",  32'(bus.res_valid),  0);
        check("rst_fifo_count", 32'(bus.fifo_count), 0);
        check("rst_cmd_ready",  32'(bus.cmd_ready),  1);
        check("rst_busy",       32'(bus.busy),       0);
        check("rst_lu_a",       32'(bus.lu_a),       0);
        check("rst_lu_sel",     32'(bus.lu_sel),     0);
        check("rst_res_data",   32'(bus.res_data),   0);
        rst_n = 1'b1;
        tick();

        // ---------------- Single op ----------------
        bus.res_ready = 1'b1;
        drive(8'hF0, 8'h3C, 2'b00);
        tick();                                   // push edge
        bus.cmd_valid = 1'b0;
        check("t1_count_after_push", 32'(bus.fifo_count), 1);
        check("t1_busy",             32'(bus.busy),       1);
        tick();                                   // pop edge -> ISSUE
        check("t1_lu_sel_issue", 32'(bus.lu_sel),     0);
        check("t1_lu_a_issue",   32'(bus.lu_a),       32'h F0);
        check("t1_lu_b_issue",   32'(bus.lu_b),       32'h 3C);
        check("t1_count_popped", 32'(bus.fifo_count), 0);
        check("t1_valid_edge1",  32'(bus.res_valid),  0);
        tick();
        check("t1_valid_edge2",  32'(bus.res_valid),  0);
        tick();
        check("t1_valid_edge3",  32'(bus.res_valid),  1);
        check("t1_res_data",     32'(bus.res_data),   32'h30);
        $display("single op: res_data=0x%0h", bus.res_data);
        tick();
        check("t1_valid_cleared", 32'(bus.res_valid), 0);
        check("t1_busy_idle",     32'(bus.busy),      0);

        // ---------------- All ops back-to-back ----------------
        n         = 0;
        max_count = 0;
        drive(8'hF0, 8'h3C, 2'b00);
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick();                               // edge E_cyc
            if (cyc + 1 < 4) drive(8'hF0, 8'h3C, 2'(cyc + 1));
            else bus.cmd_valid = 1'b0;
            if (int'(bus.fifo_count) > max_count) max_count = int'(bus.fifo_count);
            if (bus.res_valid) begin
                if (n < 4) check("t2_res_data", 32'(bus.res_data), 32'(exp_ops[n]));
                check("t2_res_cycle", 32'(cyc), 32'(3 + 3 * n));
                $display("back-to-back result %0d: res_data=0x%0h at edge %0d", n, bus.res_data, cyc);
                n++;
            end
            if (cyc == 12) check("t2_busy_last_hold", 32'(bus.busy), 1);
            if (cyc == 13) check("t2_busy_after",     32'(bus.busy), 0);
        end
        check("t2_result_count", 32'(n),              4);
        check("t2_count_peak",   32'(max_count),      3);
        check("t2_count_drain",  32'(bus.fifo_count), 0);

        // ---------------- Full FIFO ----------------
        bus.res_ready = 1'b0;
        idx      = 0;
        accepted = 0;
        for (int c = 0; c < 10; c++) begin
            drive(fa[idx], fb[idx], fs[idx]);
            rdy = bus.cmd_ready;
            tick();
            if (rdy) begin
                accepted++;
                $display("full fifo: accepted cmd %0d", idx);
                if (idx < 5) idx++;
            end
        end
        check("t3_accepted",   32'(accepted),         5);
        check("t3_fifo_count", 32'(bus.fifo_count),   4);
        check("t3_cmd_ready",  32'(bus.cmd_ready),    0);
        check("t3_res_valid",  32'(bus.res_valid),    1);
        check("t3_res_data",   32'(bus.res_data),     32'h03);

        // ---------------- Backpressure: 10 cycles in HOLD ----------------
        for (int c = 0; c < 10; c++) begin
            tick();
            check("t4_res_valid",  32'(bus.res_valid),  1);
            check("t4_res_data",   32'(bus.res_data),   32'h03);
            check("t4_lu_a",       32'(bus.lu_a),       32'h01);
            check("t4_lu_b",       32'(bus.lu_b),       32'h02);
            check("t4_lu_sel",     32'(bus.lu_sel),     1);
            check("t4_fifo_count", 32'(bus.fifo_count), 4);
        end

        // ---------------- Single-cycle res_ready with push pending ----------------
        bus.res_ready = 1'b1;
        tick();                                   // accept + pop cmd1 on this edge
        bus.res_ready = 1'b0;
        check("t5_res_valid_clr", 32'(bus.res_valid),  0);
        check("t5_lu_a_next",     32'(bus.lu_a),       32'h0F);
        check("t5_lu_b_next",     32'(bus.lu_b),       32'hF0);
        check("t5_lu_sel_next",   32'(bus.lu_sel),     2);
        check("t5_count_popped",  32'(bus.fifo_count), 3);
        check("t5_cmd_ready",     32'(bus.cmd_ready),  1);
        tick();                                   // stalled cmd5 now pushed
        bus.cmd_valid = 1'b0;
        check("t5_count_refill",  32'(bus.fifo_count), 4);

        bus.res_ready = 1'b1;
        n = 1;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus.res_valid) begin
                if (n < 6) check("t5_drain_data", 32'(bus.res_data), 32'(fexp[n]));
                $display("drain result %0d: res_data=0x%0h", n, bus.res_data);
                n++;
            end
        end
        check("t5_drain_count", 32'(n),              6);
        check("t5_busy_end",    32'(bus.busy),       0);

        // ---------------- Reset in WAIT ----------------
        drive(8'hF0, 8'h3C, 2'b10);
        tick();                                   // push
        drive(8'h12, 8'h34, 2'b00);
        tick();                                   // pop -> ISSUE, push second
        bus.cmd_valid = 1'b0;
        tick();                                   // -> WAIT
        check("t6_pre_valid", 32'(bus.res_valid),  0);
        check("t6_pre_count", 32'(bus.fifo_count), 1);
        check("t6_pre_lu_a",  32'(bus.lu_a),       32'hF0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_res_valid", 32'(bus.res_valid),  0);
        check("t6_rst_count",     32'(bus.fifo_count), 0);
        check("t6_rst_lu_a",      32'(bus.lu_a),       0);
        check("t6_rst_lu_b",      32'(bus.lu_b),       0);
        check("t6_rst_lu_sel",    32'(bus.lu_sel),     0);
        check("t6_rst_res_data",  32'(bus.res_data),   0);
        check("t6_rst_busy",      32'(bus.busy),       0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            check("t6_no_stale_valid", 32'(bus.res_valid),  0);
            check("t6_no_stale_count", 32'(bus.fifo_count), 0);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
